// File: rtl/spu_pkg.sv
// Shared front-end types: instruction/PC widths and the fetch queue entry layout.
package spu_pkg;

   localparam int IW = 32;
   localparam int AW = 32;

   typedef struct packed {
      logic [IW-1:0] instr;
      logic [AW-1:0] pc;
      logic          taken;
      logic [AW-1:0] pred_pc;
   } fetch_entry_t;

endpackage

// File: rtl/fiq_storage.sv
// Entry array for the fetch/issue queue: FETCH_W write ports, ISSUE_W combinational read ports.
module fiq_storage
   import spu_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int FETCH_W = 2,
   parameter int ISSUE_W = 2,
   parameter int PW      = $clog2(DEPTH)
)
(
   input  logic         clk,
   input  logic [FETCH_W-1:0] wr_en,
   input  logic [PW-1:0] wr_addr [FETCH_W],
   input  fetch_entry_t wr_data [FETCH_W],
   input  logic [PW-1:0] rd_addr [ISSUE_W],
   output fetch_entry_t rd_data [ISSUE_W]
);

   fetch_entry_t mem [DEPTH];

   // Write addresses within one group are always distinct, so port order never matters.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_W; i++) begin
         if (wr_en[i]) begin
            mem[wr_addr[i]] <= wr_data[i];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < ISSUE_W; k++) begin
         rd_data[k] = mem[rd_addr[k]];
      end
   end

endmodule

// File: rtl/fetch_issue_queue.sv
// Fetch-to-decode instruction queue: accepts fetch groups (truncated after the first
// predicted-taken slot) and presents up to ISSUE_W oldest entries to decode.
module fetch_issue_queue
#(
   parameter int FETCH_W = 2,
   parameter int ISSUE_W = 2,
   parameter int DEPTH   = 8,
   parameter int IW      = spu_pkg::IW,
   parameter int AW      = spu_pkg::AW
)
(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           in_valid,
   input  logic [$clog2(FETCH_W+1)-1:0]   in_cnt,
   input  logic [FETCH_W*IW-1:0]          in_instr,
   input  logic [AW-1:0]                  in_pc,
   input  logic [FETCH_W-1:0]             in_taken,
   input  logic [FETCH_W*AW-1:0]          in_pred_pc,
   output logic                           in_ready,
   output logic [ISSUE_W-1:0]             out_valid,
   output logic [ISSUE_W*IW-1:0]          out_instr,
   output logic [ISSUE_W*AW-1:0]          out_pc,
   output logic [ISSUE_W*AW-1:0]          out_pred_pc,
   output logic [ISSUE_W-1:0]             out_taken,
   input  logic [$clog2(ISSUE_W+1)-1:0]   out_take,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   import spu_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [PW-1:0]      head;
   logic [PW-1:0]      tail;
   int                 group_n;
   int                 push_n;
   int                 pop_n;
   logic               do_push;
   logic [FETCH_W-1:0] wr_en;
   logic [PW-1:0]      wr_addr [FETCH_W];
   fetch_entry_t       wr_data [FETCH_W];
   logic [PW-1:0]      rd_addr [ISSUE_W];
   fetch_entry_t       rd_data [ISSUE_W];

   // Readiness looks only at registered occupancy so fetch never depends on decode's take.
   always_comb begin
      in_ready = (DEPTH - int'(count)) >= FETCH_W;
   end

   // Group length: in_cnt, cut just after the lowest valid predicted-taken slot.
   always_comb begin
      group_n = (int'(in_cnt) > FETCH_W) ? FETCH_W : int'(in_cnt);
      for (int i = FETCH_W-1; i >= 0; i--) begin
         if ((i < int'(in_cnt)) && in_taken[i]) begin
            group_n = i + 1;
         end
      end
      do_push = in_valid && in_ready && !flush;
      push_n  = do_push ? group_n : 0;
   end

   always_comb begin
      pop_n = int'(out_take);
      if (pop_n > int'(count)) begin
         pop_n = int'(count);
      end
      if (pop_n > ISSUE_W) begin
         pop_n = ISSUE_W;
      end
   end

   // Slot 0 sits in the MSBs of the packed group buses; PCs are implied by slot index.
   always_comb begin
      for (int i = 0; i < FETCH_W; i++) begin
         wr_en[i]           = i < push_n;
         wr_addr[i]         = tail + PW'(i);
         wr_data[i].instr   = in_instr[(FETCH_W-1-i)*IW +: IW];
         wr_data[i].pc      = in_pc + AW'(4*i);
         wr_data[i].taken   = in_taken[i];
         wr_data[i].pred_pc = in_pred_pc[(FETCH_W-1-i)*AW +: AW];
      end
   end

   fiq_storage #(
      .DEPTH   (DEPTH),
      .FETCH_W (FETCH_W),
      .ISSUE_W (ISSUE_W),
      .PW      (PW)
   ) u_storage (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      out_valid   = '0;
      out_instr   = '0;
      out_pc      = '0;
      out_pred_pc = '0;
      out_taken   = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         rd_addr[k]                             = head + PW'(k);
         out_valid[k]                           = int'(count) > k;
         out_instr[(ISSUE_W-1-k)*IW +: IW]      = rd_data[k].instr;
         out_pc[(ISSUE_W-1-k)*AW +: AW]         = rd_data[k].pc;
         out_pred_pc[(ISSUE_W-1-k)*AW +: AW]    = rd_data[k].pred_pc;
         out_taken[k]                           = rd_data[k].taken;
      end
   end

   // The reset input is active-low; flush takes priority over any same-cycle push or pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(pop_n);
         tail  <= tail + PW'(push_n);
         count <= CW'(int'(count) + push_n - pop_n);
      end
   end

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Self-checking bench for fetch_issue_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fetch_issue_queue;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [1:0]  in_cnt;
   logic [63:0] in_instr;
   logic [31:0] in_pc;
   logic [1:0]  in_taken;
   logic [63:0] in_pred_pc;
   logic        in_ready;
   logic [1:0]  out_valid;
   logic [63:0] out_instr;
   logic [63:0] out_pc;
   logic [63:0] out_pred_pc;
   logic [1:0]  out_taken;
   logic [1:0]  out_take;
   logic [3:0]  count;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pred;
      logic        taken;
   } ent_t;

   ent_t model_q[$];
   int   assertions = 0;
   int   failures   = 0;

   fetch_issue_queue dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_cnt      (in_cnt),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .in_taken    (in_taken),
      .in_pred_pc  (in_pred_pc),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_pred_pc (out_pred_pc),
      .out_taken   (out_taken),
      .out_take    (out_take),
      .count       (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      assertions++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference behaviour: drop everything on flush, else pop the oldest, then append the group.
   task automatic modelStep();
      int pop;
      ent_t e;
      if (flush) begin
         model_q.delete();
      end else begin
         bit ready = (8 - model_q.size()) >= 2;
         pop = int'(out_take);
         if (pop > model_q.size()) pop = model_q.size();
         if (pop > 2) pop = 2;
         repeat (pop) void'(model_q.pop_front());
         if (in_valid && ready) begin
            for (int i = 0; i < int'(in_cnt) && i < 2; i++) begin
               e.instr = in_instr[(1-i)*32 +: 32];
               e.pc    = in_pc + 32'(4*i);
               e.pred  = in_pred_pc[(1-i)*32 +: 32];
               e.taken = in_taken[i];
               model_q.push_back(e);
               if (in_taken[i]) break;
            end
         end
      end
   endtask

   task automatic checkState(input string tag);
      int sz = model_q.size();
      logic [1:0] expv = (sz >= 2) ? 2'b11 : ((sz == 1) ? 2'b01 : 2'b00);
      checkOutput({tag, ".count"}, 64'(count), 64'(sz));
      checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'((8 - sz) >= 2));
      checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(expv));
      for (int k = 0; k < 2 && k < sz; k++) begin
         checkOutput($sformatf("%s.pc%0d", tag, k), 64'(out_pc[(1-k)*32 +: 32]), 64'(model_q[k].pc));
         checkOutput($sformatf("%s.instr%0d", tag, k), 64'(out_instr[(1-k)*32 +: 32]), 64'(model_q[k].instr));
         checkOutput($sformatf("%s.pred%0d", tag, k), 64'(out_pred_pc[(1-k)*32 +: 32]), 64'(model_q[k].pred));
         checkOutput($sformatf("%s.taken%0d", tag, k), 64'(out_taken[k]), 64'(model_q[k].taken));
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] cnt, input logic [1:0] tk,
                                input logic [31:0] pc, input logic [1:0] take, input logic fl);
      in_valid   = v;
      in_cnt     = cnt;
      in_taken   = tk;
      in_pc      = pc;
      in_instr   = {$urandom, $urandom};
      in_pred_pc = {$urandom, $urandom};
      out_take   = take;
      flush      = fl;
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkState(tag);
   endtask

   initial begin
      reset = 1'b0;
      applyStimulus(1'b0, 2'd0, 2'b00, 32'h0, 2'd0, 1'b0);
      #2;
      checkOutput("reset.count", 64'(count), 64'd0);
      checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset.in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b1;

      // Basic two-entry push, then fill to full.
      applyStimulus(1'b1, 2'd2, 2'b00, 32'h100, 2'd0, 1'b0);
      in_instr = {32'hAAAA0000, 32'hBBBB0000};
      tick("push2");
      checkOutput("push2.count", 64'(count), 64'd2);
      checkOutput("push2.out_valid", 64'(out_valid), 64'h3);
      checkOutput("push2.pc0", 64'(out_pc[63:32]), 64'h100);
      checkOutput("push2.pc1", 64'(out_pc[31:0]), 64'h104);
      checkOutput("push2.instr0", 64'(out_instr[63:32]), 64'hAAAA0000);
      for (int g = 0; g < 3; g++) begin
         applyStimulus(1'b1, 2'd2, 2'b00, 32'h200 + 32'(g*8), 2'd0, 1'b0);
         tick("fill");
      end
      checkOutput("full.count", 64'(count), 64'd8);
      checkOutput("full.in_ready", 64'(in_ready), 64'd0);
      applyStimulus(1'b1, 2'd2, 2'b00, 32'h300, 2'd0, 1'b0);
      tick("overfill");
      checkOutput("overfill.count", 64'(count), 64'd8);

      // At 7 entries a push is refused while the pop still happens.
      applyStimulus(1'b0, 2'd0, 2'b00, 32'h0, 2'd1, 1'b0);
      tick("pop1");
      checkOutput("seven.in_ready", 64'(in_ready), 64'd0);
      applyStimulus(1'b1, 2'd2, 2'b00, 32'h400, 2'd2, 1'b0);
      tick("popnopush");
      checkOutput("popnopush.count", 64'(count), 64'd5);

      // Flush overrides simultaneous push and pop.
      applyStimulus(1'b1, 2'd2, 2'b00, 32'h500, 2'd2, 1'b1);
      tick("flush");
      checkOutput("flush.count", 64'(count), 64'd0);
      checkOutput("flush.out_valid", 64'(out_valid), 64'd0);
      checkOutput("flush.in_ready", 64'(in_ready), 64'd1);

      // Taken slot 0 truncates the group to one entry.
      applyStimulus(1'b1, 2'd2, 2'b01, 32'h600, 2'd0, 1'b0);
      tick("trunc");
      checkOutput("trunc.count", 64'(count), 64'd1);
      checkOutput("trunc.out_taken0", 64'(out_taken[0]), 64'd1);
      checkOutput("trunc.out_valid", 64'(out_valid), 64'h1);

      // Build to six entries, then reset asynchronously between edges.
      applyStimulus(1'b1, 2'd2, 2'b00, 32'h700, 2'd0, 1'b0);
      tick("build");
      applyStimulus(1'b1, 2'd2, 2'b00, 32'h708, 2'd0, 1'b0);
      tick("build");
      applyStimulus(1'b1, 2'd1, 2'b00, 32'h710, 2'd0, 1'b0);
      tick("build");
      checkOutput("six.count", 64'(count), 64'd6);
      applyStimulus(1'b0, 2'd0, 2'b00, 32'h0, 2'd0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("asyncrst.count", 64'(count), 64'd0);
      checkOutput("asyncrst.out_valid", 64'(out_valid), 64'd0);
      checkOutput("asyncrst.in_ready", 64'(in_ready), 64'd1);
      model_q.delete();
      #1;
      reset = 1'b1;
      applyStimulus(1'b1, 2'd2, 2'b00, 32'h1000, 2'd0, 1'b0);
      tick("postrst");
      checkOutput("postrst.count", 64'(count), 64'd2);

      // Steady one-in/one-out stream walks head and tail around the array.
      for (int n = 0; n < 20; n++) begin
         applyStimulus(1'b1, 2'd1, 2'b00, 32'h1008 + 32'(4*n), 2'd1, 1'b0);
         tick("wrap");
      end

      // Random traffic, including excess take values and occasional flushes.
      for (int n = 0; n < 400; n++) begin
         logic [1:0] tk;
         tk = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 2)), tk,
                       $urandom & 32'hFFFF_FFFC, 2'($urandom_range(0, 3)),
                       $urandom_range(0, 29) == 0);
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
